tb_mmio_console: RTL and testbench

- Parametrised memory-mapped simulation console for the RS5 platform; replaces the ad-hoc output/end registers.
- Provides NCH character output channels, each with its own buffering FIFO and ready/valid drain port.
- Provides an end-of-simulation register with a latched exit code, and a watchdog timeout that halts a runaway program.
- Sits on the data bus behind the address decoder, in the 0x8 region.
- Read data is returned one cycle after the access, matching the registered read-mux timing.

---
 rtl/tb_mmio_console.sv | 185 ++++++++++++++++++
 tb/tb_tb_mmio_console.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tb_mmio_console.sv
// Memory-mapped simulation console: NCH buffered character channels, end-of-run
// register with latched exit code, and a watchdog that stops a runaway program.
module tb_mmio_console #(
    parameter int                NCH       = 2,
    parameter int                DEPTH     = 16,
    parameter int                ADDR_W    = 12,
    parameter int                WDOG_W    = 32,
    parameter logic [WDOG_W-1:0] WDOG_INIT = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_i,
    input  logic [3:0]          we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [31:0]         data_i,
    output logic [31:0]         data_o,
    output logic [NCH-1:0]      char_valid_o,
    output logic [8*NCH-1:0]    char_data_o,
    input  logic [NCH-1:0]      char_ready_i,
    output logic                end_o,
    output logic                timeout_o,
    output logic [31:0]         exit_code_o
);
    // state   | meaning
    // S_RUN   | normal operation, TX pushes accepted, watchdog counting
    // S_DRAIN | END written, waiting for every FIFO to empty
    // S_DONE  | finished (terminal until reset), FIFOs may still drain
    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int              PW       = $clog2(DEPTH);
    localparam int              LW       = PW + 1;
    localparam logic [LW-1:0]   FULL_LVL = LW'(DEPTH);
    localparam logic [ADDR_W-1:0] A_END  = ADDR_W'(12'hF00);
    localparam logic [ADDR_W-1:0] A_WDOG = ADDR_W'(12'hF04);

    state_t               r_state, w_state_nxt;
    logic [7:0]           r_mem   [NCH][DEPTH];
    logic [PW-1:0]        r_wptr  [NCH];
    logic [PW-1:0]        r_rptr  [NCH];
    logic [LW-1:0]        r_level [NCH];
    logic [15:0]          r_drops [NCH];
    logic [WDOG_W-1:0]    r_wdog_cnt, r_wdog_reload;

    logic                 w_wr, w_rd, w_ch_hit, w_end_wr, w_wdog_wr;
    logic                 w_wdog_tick, w_wdog_expire, w_all_empty;
    logic [4:0]           w_ch_idx;
    logic [3:0]           w_off;
    logic [NCH-1:0]       w_push, w_pop, w_drop, w_drop_clr;
    logic [31:0]          w_rdata;

    assign w_wr      = enable_i && (we_i != 4'h0);
    assign w_rd      = enable_i && (we_i == 4'h0);
    assign w_ch_idx  = {1'b0, addr_i[7:4]};
    assign w_off     = addr_i[3:0];
    assign w_ch_hit  = (addr_i[ADDR_W-1:8] == '0) && (w_ch_idx < 5'(NCH));
    assign w_end_wr  = w_wr && (addr_i == A_END);
    assign w_wdog_wr = w_wr && (addr_i == A_WDOG);

    // A reload on the same edge takes priority over counting, so it can rescue a 1 -> 0 expiry.
    assign w_wdog_tick   = (r_state == S_RUN) && !w_wdog_wr &&
                           (r_wdog_cnt != '0) && (r_wdog_reload != '0);
    assign w_wdog_expire = w_wdog_tick && (r_wdog_cnt == WDOG_W'(1));

    always_comb begin
        w_push      = '0;
        w_pop       = '0;
        w_drop      = '0;
        w_drop_clr  = '0;
        w_all_empty = 1'b1;
        w_rdata     = '0;
        for (int c = 0; c < NCH; c++) begin
            w_pop[c] = (r_level[c] != '0) && char_ready_i[c];
            if (r_level[c] != '0)
                w_all_empty = 1'b0;
            if (w_ch_hit && (w_ch_idx == 5'(c))) begin
                // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
                if (w_wr && (w_off == 4'h0) && we_i[0] && (r_state == S_RUN)) begin
                    if ((r_level[c] != FULL_LVL) || w_pop[c])
                        w_push[c] = 1'b1;
                    else
                        w_drop[c] = 1'b1;
                end
                if (w_wr && (w_off == 4'h8))
                    w_drop_clr[c] = 1'b1;
                if (w_off == 4'h4)
                    w_rdata = {16'h0, 8'(r_level[c]), 6'h0,
                               (r_level[c] == '0), (r_level[c] == FULL_LVL)};
                if (w_off == 4'h8)
                    w_rdata = {16'h0, r_drops[c]};
            end
        end
        if (addr_i == A_END)
            w_rdata = exit_code_o;
        if (addr_i == A_WDOG)
            w_rdata = 32'(r_wdog_cnt);
    end

    always_comb begin
        char_valid_o = '0;
        char_data_o  = '0;
        for (int c = 0; c < NCH; c++) begin
            char_valid_o[c] = (r_level[c] != '0);
            if (r_level[c] != '0)
                char_data_o[8*c +: 8] = r_mem[c][r_rptr[c]];
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++)
            if (w_push[c])
                r_mem[c][r_wptr[c]] <= data_i[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                r_wptr[c]  <= '0;
                r_rptr[c]  <= '0;
                r_level[c] <= '0;
                r_drops[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_push[c])
                    r_wptr[c] <= r_wptr[c] + PW'(1);
                if (w_pop[c])
                    r_rptr[c] <= r_rptr[c] + PW'(1);
                case ({w_push[c], w_pop[c]})
                    2'b10:   r_level[c] <= r_level[c] + LW'(1);
                    2'b01:   r_level[c] <= r_level[c] - LW'(1);
                    default: ;
                endcase
                if (w_drop_clr[c])
                    r_drops[c] <= '0;
                else if (w_drop[c] && (r_drops[c] != 16'hFFFF))
                    r_drops[c] <= r_drops[c] + 16'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (w_end_wr)
                    w_state_nxt = S_DRAIN;
                else if (w_wdog_expire)
                    w_state_nxt = S_DONE;
            end
            S_DRAIN: if (w_all_empty) w_state_nxt = S_DONE;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_RUN;
            end_o         <= 1'b0;
            timeout_o     <= 1'b0;
            exit_code_o   <= '0;
            data_o        <= '0;
            r_wdog_cnt    <= WDOG_INIT;
            r_wdog_reload <= WDOG_INIT;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_RUN) && w_end_wr) begin
                exit_code_o <= data_i;
            end else if ((r_state == S_RUN) && w_wdog_expire) begin
                exit_code_o <= 32'hDEAD0001;
                timeout_o   <= 1'b1;
                end_o       <= 1'b1;
            end
            if ((r_state == S_DRAIN) && w_all_empty)
                end_o <= 1'b1;
            if (w_wdog_wr) begin
                r_wdog_reload <= WDOG_W'(data_i);
                r_wdog_cnt    <= WDOG_W'(data_i);
            end else if (w_wdog_tick) begin
                r_wdog_cnt <= r_wdog_cnt - WDOG_W'(1);
            end
            if (w_rd)
                data_o <= w_rdata;
        end
    end
endmodule

// File: tb/tb_tb_mmio_console.sv
// Scoreboard bench for tb_mmio_console: read data and popped characters are
// checked by monitors against queues filled when stimulus is issued.
module tb_tb_mmio_console;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable_i = 1'b0;
    logic [3:0]  we_i = 4'h0;
    logic [11:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic [1:0]  char_valid_o;
    logic [15:0] char_data_o;
    logic [1:0]  char_ready_i = 2'b00;
    logic        end_o, timeout_o;
    logic [31:0] exit_code_o;

    logic [31:0] exp_q[$];
    logic [7:0]  exp_c0[$];
    logic [7:0]  exp_c1[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        rd_d;

    tb_mmio_console #(.NCH(2), .DEPTH(16), .ADDR_W(12), .WDOG_W(32), .WDOG_INIT(32'h0)) dut (
        .clk(clk), .reset(reset), .enable_i(enable_i), .we_i(we_i), .addr_i(addr_i),
        .data_i(data_i), .data_o(data_o), .char_valid_o(char_valid_o),
        .char_data_o(char_data_o), .char_ready_i(char_ready_i), .end_o(end_o),
        .timeout_o(timeout_o), .exit_code_o(exit_code_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge clk or posedge reset)
        if (reset) rd_d <= 1'b0;
        else       rd_d <= enable_i && (we_i == 4'h0);

    always @(negedge clk) begin
        if (!reset && rd_d) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL read: unexpected data 0x%08h with nothing expected", data_o);
            end else
                chk("read data", data_o, exp_q.pop_front());
        end
        if (!reset && char_valid_o[0] && char_ready_i[0]) begin
            if (exp_c0.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL ch0 pop: unexpected byte 0x%02h", char_data_o[7:0]);
            end else
                chk("ch0 pop", {24'h0, char_data_o[7:0]}, {24'h0, exp_c0.pop_front()});
        end
        if (!reset && char_valid_o[1] && char_ready_i[1]) begin
            if (exp_c1.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL ch1 pop: unexpected byte 0x%02h", char_data_o[15:8]);
            end else
                chk("ch1 pop", {24'h0, char_data_o[15:8]}, {24'h0, exp_c1.pop_front()});
        end
    end

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        enable_i = 1'b1; we_i = 4'hF; addr_i = a; data_i = d;
        @(posedge clk); #1;
        enable_i = 1'b0; we_i = 4'h0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] e);
        enable_i = 1'b1; we_i = 4'h0; addr_i = a;
        exp_q.push_back(e);
        @(posedge clk); #1;
        enable_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset = 1'b1; enable_i = 1'b0; we_i = 4'h0; char_ready_i = 2'b00;
        exp_q.delete(); exp_c0.delete(); exp_c1.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("reset data_o", data_o, 32'h0);
        chk("reset valid", {30'h0, char_valid_o}, 32'h0);
        chk("reset char_data", {16'h0, char_data_o}, 32'h0);
        chk("reset end/timeout", {30'h0, end_o, timeout_o}, 32'h0);
        chk("reset exit_code", exit_code_o, 32'h0);
        rd(12'hF04, 32'h0);
        rd(12'h004, 32'h0000_0002);

        // two characters on ch0, then drain them back to back
        wr(12'h000, 32'h48); exp_c0.push_back(8'h48);
        wr(12'h000, 32'h69); exp_c0.push_back(8'h69);
        rd(12'h004, 32'h0000_0200);
        char_ready_i[0] = 1'b1;
        idle(1);
        chk("ch0 second byte at head", {24'h0, char_data_o[7:0]}, 32'h69);
        idle(1);
        chk("ch0 empty after drain", {31'h0, char_valid_o[0]}, 32'h0);
        char_ready_i[0] = 1'b0;

        // overflow ch1: 16 accepted, 4 dropped
        for (int i = 0; i < 20; i++) begin
            wr(12'h010, 32'h60 + i);
            if (i < 16) exp_c1.push_back(8'(8'h60 + i));
        end
        rd(12'h014, 32'h0000_1001);
        rd(12'h018, 32'd4);
        wr(12'h018, 32'h0);
        rd(12'h018, 32'd0);
        char_ready_i[1] = 1'b1;
        idle(17);
        char_ready_i[1] = 1'b0;
        chk("ch1 drained", {30'h0, char_valid_o}, 32'h0);

        // full ch0 with simultaneous push and pop
        for (int i = 0; i < 16; i++) begin
            wr(12'h000, 32'h30 + i);
            exp_c0.push_back(8'(8'h30 + i));
        end
        char_ready_i[0] = 1'b1;
        wr(12'h000, 32'hAA); exp_c0.push_back(8'hAA);
        char_ready_i[0] = 1'b0;
        rd(12'h004, 32'h0000_1001);
        rd(12'h008, 32'd0);
        char_ready_i[0] = 1'b1;
        idle(17);
        char_ready_i[0] = 1'b0;

        // END with bytes queued: drain then finish
        do_reset();
        wr(12'h000, 32'h41); exp_c0.push_back(8'h41);
        wr(12'h000, 32'h42); exp_c0.push_back(8'h42);
        wr(12'h000, 32'h43); exp_c0.push_back(8'h43);
        wr(12'hF00, 32'h2A);
        idle(1);
        chk("end low in drain", {31'h0, end_o}, 32'h0);
        wr(12'h000, 32'h55);
        rd(12'h004, 32'h0000_0300);
        rd(12'h008, 32'd0);
        char_ready_i[0] = 1'b1;
        idle(3);
        chk("end low before empty seen", {31'h0, end_o}, 32'h0);
        idle(1);
        chk("end after drain", {31'h0, end_o}, 32'h1);
        chk("drain timeout", {31'h0, timeout_o}, 32'h0);
        chk("drain exit_code", exit_code_o, 32'h2A);
        char_ready_i[0] = 1'b0;
        rd(12'hF00, 32'h2A);
        wr(12'hF00, 32'h99);
        idle(1);
        chk("END ignored in DONE", exit_code_o, 32'h2A);

        // watchdog expiry
        do_reset();
        wr(12'hF04, 32'd10);
        idle(9);
        chk("wdog not yet", {31'h0, end_o}, 32'h0);
        idle(1);
        chk("wdog end", {31'h0, end_o}, 32'h1);
        chk("wdog timeout", {31'h0, timeout_o}, 32'h1);
        chk("wdog exit_code", exit_code_o, 32'hDEAD0001);
        rd(12'hF04, 32'h0);

        // periodic rewrite keeps the program alive
        do_reset();
        wr(12'hF04, 32'd10);
        for (int i = 0; i < 6; i++) begin
            idle(4);
            wr(12'hF04, 32'd10);
        end
        rd(12'hF04, 32'd10);
        chk("kicked wdog no end", {30'h0, end_o, timeout_o}, 32'h0);

        // reload on the expiry edge wins
        wr(12'hF04, 32'd3);
        idle(2);
        wr(12'hF04, 32'd3);
        chk("reload at expiry", {30'h0, end_o, timeout_o}, 32'h0);
        rd(12'hF04, 32'd3);
        wr(12'hF04, 32'd0);
        idle(20);
        chk("wdog disabled", {30'h0, end_o, timeout_o}, 32'h0);

        // END write on the expiry edge wins
        do_reset();
        wr(12'hF04, 32'd3);
        idle(2);
        wr(12'hF00, 32'h77);
        idle(1);
        chk("END vs expiry end", {30'h0, end_o, timeout_o}, 32'h2);
        chk("END vs expiry exit", exit_code_o, 32'h77);

        // asynchronous reset during drain
        do_reset();
        wr(12'h010, 32'h11);
        wr(12'h010, 32'h12);
        wr(12'h010, 32'h13);
        wr(12'hF00, 32'h5);
        rd(12'h014, 32'h0000_0300);
        idle(1);
        #2 reset = 1'b1;
        exp_q.delete(); exp_c0.delete(); exp_c1.delete();
        #1;
        chk("async rst data_o", data_o, 32'h0);
        chk("async rst valid", {30'h0, char_valid_o}, 32'h0);
        chk("async rst exit", exit_code_o, 32'h0);
        chk("async rst end", {30'h0, end_o, timeout_o}, 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        wr(12'h000, 32'h7E); exp_c0.push_back(8'h7E);
        rd(12'h004, 32'h0000_0100);
        rd(12'h014, 32'h0000_0002);
        char_ready_i[0] = 1'b1;
        idle(2);
        char_ready_i[0] = 1'b0;
        idle(2);

        chk("read queue empty", exp_q.size(), 32'h0);
        chk("ch0 queue empty", exp_c0.size(), 32'h0);
        chk("ch1 queue empty", exp_c1.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
